// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage plus the IF/ID pipeline register.
// Holds the PC, drives the combinational instruction memory address, and
// latches {instruction, PC+4, valid} for decode. Handles stalls, flushes,
// branch/jump redirects, misaligned-target detection and a fetch counter.
//
// Build option: define FETCH_DELAY_SLOT_EN for MIPS branch-delay-slot
// behaviour (the instruction after a redirect is kept). Left undefined, that
// instruction is squashed into a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        align_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t      state_q, state_d;

  logic [31:0] pc_p0, pc_p0_d;
  logic [31:0] pc4_p0;

  logic [31:0] instr_p1, instr_p1_d;
  logic [31:0] pc4_p1, pc4_p1_d;
  logic        vld_p1, vld_p1_d;
  logic        align_q, align_d;
  logic [31:0] count_q, count_d;

  // ---- Stage p0: program counter and instruction-memory request ----
  assign pc4_p0    = pc_p0 + 32'd4;
  assign imem_addr = pc_p0;
  assign imem_en   = !Reset && !stall;

  // Next-state selection: stall holds everything, then redirect, flush, normal.
  always_comb begin
    pc_p0_d    = pc_p0;
    instr_p1_d = instr_p1;
    pc4_p1_d   = pc4_p1;
    vld_p1_d   = vld_p1;
    align_d    = align_q;
    state_d    = state_q;
    if (stall) begin
      state_d = state_q;
    end else if (redirect) begin
      pc_p0_d  = {redirect_target[31:2], 2'b00};
      align_d  = align_q | (redirect_target[1:0] != 2'b00);
      state_d  = REDIR;
      pc4_p1_d = pc4_p0;
`ifdef FETCH_DELAY_SLOT_EN
      // Delay slot: the sequential instruction still executes; flush is ignored.
      instr_p1_d = imem_data;
      vld_p1_d   = 1'b1;
`else
      // No delay slot: the instruction behind the branch is squashed.
      instr_p1_d = NOP_WORD;
      vld_p1_d   = 1'b0;
`endif
    end else if (flush) begin
      pc_p0_d    = pc4_p0;
      instr_p1_d = NOP_WORD;
      pc4_p1_d   = pc4_p0;
      vld_p1_d   = 1'b0;
      state_d    = RUN;
    end else begin
      pc_p0_d    = pc4_p0;
      instr_p1_d = imem_data;
      pc4_p1_d   = pc4_p0;
      vld_p1_d   = 1'b1;
      state_d    = RUN;
    end
  end

  // The counter only advances on edges that actually load a real instruction.
  assign count_d = count_q + {31'd0, (!stall && vld_p1_d)};

  // ---- Stage p1: IF/ID register, PC update, sticky flags and FSM state ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_p0    <= RESET_PC;
      instr_p1 <= NOP_WORD;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
      align_q  <= 1'b0;
      count_q  <= 32'd0;
      state_q  <= RUN;
    end else begin
      pc_p0    <= pc_p0_d;
      instr_p1 <= instr_p1_d;
      pc4_p1   <= pc4_p1_d;
      vld_p1   <= vld_p1_d;
      align_q  <= align_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  assign if_id_instr = instr_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;
  assign align_err   = align_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS datapath. Holds the program counter, drives the byte address of the instruction memory, and latches the returned 32-bit big-endian word with its PC+4 into the IF/ID register. Decode consumes that register. Decode also returns branch/jump redirects, and the hazard unit returns stalls.

## Interface
- `RESET_PC`, default 32'h00000000: PC value loaded on reset.
- `NOP_WORD`, default 32'h00000000: encoding injected as a bubble (`sll $0,$0,0`).
- `Clk` input, 1 bit: single clock; all state updates on the rising edge.
- `Reset` input, 1 bit: reset is synchronous and active-high.
- `stall` input, 1 bit: hazard unit; holds the PC and the IF/ID register.
- `flush` input, 1 bit: replaces the IF/ID contents with a bubble.
- `redirect` input, 1 bit: taken branch or jump from decode.
- `redirect_target` input, 32 bits: new PC when `redirect` is high.
- `imem_data` input, 32 bits: word read combinationally at `imem_addr`.
- `imem_addr` output, 32 bits: current PC (byte address).
- `imem_en` output, 1 bit: fetch enable, equal to `!Reset && !stall`.
- `if_id_instr` output, 32 bits: latched instruction.
- `if_id_pc4` output, 32 bits: PC+4 of the latched instruction.
- `if_id_valid` output, 1 bit: latched instruction is real, not a bubble.
- `align_err` output, 1 bit: sticky flag, set when a redirect target is misaligned.
- `fetch_count` output, 32 bits: number of valid instructions latched since reset.

## Operation
- `pc` register. `imem_addr = pc`. `pc4 = pc + 32'd4`, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- Next-state priority, highest first, evaluated every rising edge:
  1. Reset: `pc = RESET_PC`, `if_id_instr = NOP_WORD`, `if_id_pc4 = 0`, `if_id_valid = 0`, `align_err = 0`, `fetch_count = 0`.
  2. Stall: `pc` and the whole IF/ID register hold. Redirect and flush are ignored; decode re-presents them after the stall.
  3. Redirect: `pc = {redirect_target[31:2], 2'b00}`. If `redirect_target[1:0] != 0`, set `align_err`. The IF/ID load depends on the configuration (see below).
  4. Flush without redirect: `pc = pc4`, IF/ID loads a bubble.
  5. Normal: `pc = pc4`, IF/ID loads `{imem_data, pc4, valid=1}`.
- Bubble load means `if_id_instr = NOP_WORD`, `if_id_pc4` = the PC+4 that would have been latched, and `if_id_valid = 0`.
- `fetch_count` increments exactly when IF/ID loads with valid=1. It wraps at 2^32.
- Fetch FSM states:
  - RUN: normal fetching.
  - REDIR: one cycle following a redirect. `if_id_valid` reflects the delay-slot or bubble policy.
  - Transitions:
    - RUN→REDIR on an accepted redirect.
    - REDIR→RUN on the next non-stalled edge.
    - A new redirect while in REDIR is accepted and the FSM stays in REDIR.
    - A stall in REDIR holds the state.
    - Reset goes to RUN from any state.

## Timing
- Instruction memory is combinational. The word at `pc` is captured at the same edge that advances `pc`.
- Fetch-to-IF/ID latency is 1 cycle.
- Redirect penalty:
  - 0 bubbles with the delay slot enabled.
  - 1 bubble with the delay slot disabled.
- Reset mid-operation discards any pending redirect or stall on that edge.
- First valid output: the edge after `Reset` falls, with `if_id_pc4 = RESET_PC + 4`.
- `align_err` stays high until Reset.

## Configuration
- `FETCH_DELAY_SLOT_EN` defined:
  - MIPS branch delay slot.
  - On a redirect, IF/ID loads the sequential instruction `{imem_data, pc4, valid=1}`.
  - `flush` coincident with a redirect is ignored for that edge.
- `FETCH_DELAY_SLOT_EN` undefined:
  - On a redirect, IF/ID loads a bubble; the instruction after the branch is squashed.
  - `fetch_count` does not count it.

## Test plan
- Reset test:
  - Stimulus: `RESET_PC = 0`, memory at addresses 0..7 = 32'h2401002C and 32'h90220000; assert Reset for 2 cycles, then release.
  - Required: at every edge with Reset high, `if_id_valid = 0` and `imem_addr = 0`.
  - Required, after release: 1st edge gives `if_id_instr = 32'h2401002C`, `if_id_pc4 = 4`; 2nd edge gives 32'h90220000, `if_id_pc4 = 8`; then `fetch_count = 2`.
- Stall test: `stall` high for 3 cycles at `pc = 8` → `imem_addr` stays 8, IF/ID unchanged, `fetch_count` unchanged, `imem_en = 0`.
- Redirect test:
  - Stimulus: at `pc = 24`, `redirect = 1`, `redirect_target = 16`.
  - Required: next `pc = 16`.
  - With the macro: IF/ID holds the word at address 24, valid=1.
  - Without the macro: `if_id_instr = 0`, valid=0, `fetch_count` unchanged.
- Flush and collision test:
  - `flush` alone → bubble, `pc` advances by 4.
  - `stall` + `redirect` together → `pc` held, redirect ignored.
  - `redirect_target = 32'h0000001A` → `pc = 32'h18`, `align_err = 1` and held until Reset.
- Wrap test: force `pc = 32'hFFFFFFFC` via redirect → next `pc = 0`, `if_id_pc4 = 0`.
- Mid-operation reset: Reset asserted in the same cycle as a redirect to 40 → `pc = RESET_PC`, FSM in RUN, all outputs at reset values.
